// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/subtract engine.
// Two WIDTH-bit operands are accepted over a valid/ready handshake and
// processed one bit per clock, LSB first, through a single full-adder
// slice with a registered carry. The result, carry and signed-overflow
// flags are returned over a second valid/ready handshake.
// Optional build macro: SERIAL_ADD_SUB_SAT_EN enables signed saturation
// of the result on overflow. The flags always report the unsaturated
// values.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg;
  logic             overflow_reg;

  logic             s_bit;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_sum;

  // The single full-adder slice working on the current LSBs.
  assign s_bit      = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) |
                      (a_sh_reg[0] & carry_reg)   |
                      (b_sh_reg[0] & carry_reg);
  assign last_bit   = (state_reg == RUN) && (cnt_reg == LAST_BIT);
  assign res_next   = {s_bit, res_reg[WIDTH-1:1]};

  // Result value written on DONE entry (wrapped, or saturated if enabled).
  // On the last bit carry_reg is the carry into the MSB, so
  // carry_reg ^ carry_next is the signed-overflow flag.
  always_comb begin
    final_sum = res_next;
`ifdef SERIAL_ADD_SUB_SAT_EN
    // On overflow the true sign is the inverse of the wrapped MSB:
    // wrapped MSB 1 means positive overflow, so clamp to the max positive value.
    if (carry_reg ^ carry_next) begin
      if (s_bit) begin
        final_sum = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        final_sum = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end
`endif
  end

  // Control FSM and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Operand loading and shifting, carry update and result collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      // Subtraction is A + ~B + 1: B is inverted and the +1 enters as carry-in.
      a_sh_reg  <= a;
      b_sh_reg  <= sub ? ~b : b;
      res_reg   <= '0;
      carry_reg <= sub;
    end else if (state_reg == RUN) begin
      a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
      b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
      res_reg   <= res_next;
      carry_reg <= carry_next;
    end
  end

  // Output registers, written only on DONE entry and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (last_bit) begin
      sum_reg       <= final_sum;
      carry_out_reg <= carry_next;
      overflow_reg  <= carry_reg ^ carry_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH = 8).
// Directed vector table, backpressure and abort sequences, then random
// operations checked against an integer-arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 8;

`ifdef SERIAL_ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic, no bit slicing of a datapath.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       output logic [W-1:0] es, output logic ec, output logic eov);
    int ua, ub, sa, sb, r, smax, smin;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    r = msub ? sa - sb : sa + sb;
    eov = (r > smax) || (r < smin);
    ec  = msub ? (ua >= ub) : ((ua + ub) >= (1 << W));
    es  = W'(r);
    if (SAT && r > smax) es = W'(smax);
    if (SAT && r < smin) es = W'(smin);
  endtask

  // Present one operand set (called at #1 after a rising edge, engine idle),
  // then wait for out_valid and capture the result. Does not complete the output handshake.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                       output logic [W-1:0] rs, output logic rc, output logic rov, output int lat);
    a = ta;
    b = tb_v;
    sub = tsub;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble operands: they must have been captured on the accept edge.
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rs  = sum;
    rc  = carry_out;
    rov = overflow;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tsub, input logic [W-1:0] es, input logic ec, input logic eov);
    logic [W-1:0] rs;
    logic rc, rov;
    int lat;
    do_op(ta, tb_v, tsub, rs, rc, rov, lat);
    $display("%s: a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h c=%0d ov=%0d lat=%0d (exp 0x%02h %0d %0d)",
             tag, ta, tb_v, tsub, rs, rc, rov, lat, es, ec, eov);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_sum"}, 32'(rs), 32'(es));
    check({tag, "_carry"}, 32'(rc), 32'(ec));
    check({tag, "_overflow"}, 32'(rov), 32'(eov));
    finish_op();
  endtask

  initial begin
    vec_t vecs[5];
    logic [W-1:0] rs, es;
    logic rc, rov, ec, eov;
    logic [W-1:0] ra, rb;
    logic rsub;
    int lat, ov_seen;

    vecs[0] = '{a: 8'h3C, b: 8'h1A, sub: 1'b0, s: 8'h56, c: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, c: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: (SAT ? 8'h7F : 8'h80), c: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h05, b: 8'h07, sub: 1'b1, s: 8'hFE, c: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, s: (SAT ? 8'h80 : 8'h7F), c: 1'b1, ov: 1'b1};

    // Power-on reset.
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                    vecs[i].s, vecs[i].c, vecs[i].ov);
    end

    // Result holds in IDLE until the next DONE entry.
    @(posedge clk);
    #1;
    check("idle_hold_sum", 32'(sum), 32'(vecs[4].s));

    // Backpressure: hold out_ready low in DONE with in_valid asserted.
    do_op(8'h3C, 8'h1A, 1'b0, rs, rc, rov, lat);
    $display("backpressure: sum=0x%02h lat=%0d", rs, lat);
    check("bp_latency", 32'(lat), 32'(W));
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_sum_stable", 32'(sum), 32'h56);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_high", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    finish_op();
    @(posedge clk);
    #1;
    check("bp_no_spurious_accept", 32'(in_ready), 32'd1);
    check("bp_sum_after", 32'(sum), 32'h56);

    // Abort: reset on the 3rd RUN cycle.
    a = 8'h11;
    b = 8'h22;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_running", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum_cleared", 32'(sum), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ov_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen++;
    end
    $display("abort: out_valid pulses after reset = %0d", ov_seen);
    check("abort_no_out_valid", 32'(ov_seen), 32'd0);
    check("abort_idle", 32'(in_ready), 32'd1);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rsub = 1'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h80; rsub = 1'b0; end
      if (i == 1) begin ra = 8'h00; rb = 8'h00; rsub = 1'b1; end
      model(ra, rb, rsub, es, ec, eov);
      run_and_check($sformatf("rand%0d", i), ra, rb, rsub, es, ec, eov);
    end

    // Reset mid-idle clears the held result.
    rst = 1'b1;
    #1;
    check("idle_reset_sum", 32'(sum), 32'd0);
    check("idle_reset_carry", 32'(carry_out), 32'd0);
    check("idle_reset_overflow", 32'(overflow), 32'd0);
    check("idle_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
